// File: rtl/pipelined_right_shifter_pkg.sv
// Shared definitions for the pipelined right shifter: datapath widths,
// operation encodings and the fill-bit helper used at the input stage.
package shifter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SRL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_ROR  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_e;

    // Only an arithmetic shift replicates the sign; everything else fills with zero.
    function automatic logic fill_for(input logic [1:0] op, input logic msb);
        return (op == OP_SRA) && msb;
    endfunction

endpackage

// File: rtl/pipelined_right_shifter_if.sv
// Handshake bundle for the pipelined right shifter: an input channel
// (operand, amount, op, tag) and an output channel (result, tag).
// The slave modport is the shifter side, the master modport the client side.
interface pipelined_right_shifter_if
    import shifter_pkg::*;
#(
    parameter int TAG_W = 5
);

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/pipelined_right_shifter_stage.sv
// One conditional step of the right barrel shifter (module right_shift_stage).
// When enabled it shifts right by SHIFT_BY, refilling the top either with
// the supplied fill bit or, for rotates, with the bits falling off the bottom.
module right_shift_stage #(
    parameter int DATA_W   = 32,
    parameter int SHIFT_BY = 1
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              enable,
    input  logic              fill,
    input  logic              rotate,
    output logic [DATA_W-1:0] data_out
);

    // Pass through unless this step is selected by its shift-amount bit.
    always_comb begin
        data_out = data_in;
        if (enable) begin
            if (rotate) begin
                data_out = {data_in[SHIFT_BY-1:0], data_in[DATA_W-1:SHIFT_BY]};
            end else begin
                data_out = {{SHIFT_BY{fill}}, data_in[DATA_W-1:SHIFT_BY]};
            end
        end
    end

endmodule

// File: rtl/pipelined_right_shifter.sv
// Two-stage pipelined 32-bit right shifter (SRL/SRA, op 11 behaves as SRL).
// Stage 1 applies the 16/8 steps, stage 2 the 4/2/1 steps into the output
// register. Define RIGHT_SHIFTER_ROTATE_EN to make op 10 a rotate right;
// without it op 10 is a plain logical shift and no rotate path exists.
module pipelined_right_shifter
    import shifter_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input logic                      clock,
    input logic                      reset_n,
    pipelined_right_shifter_if.slave bus
);

    logic               s1_valid;
    logic [DATA_W-1:0]  s1_data;
    logic [2:0]         s1_shamt;
    logic               s1_fill;
    logic               s1_rotate;
    logic [TAG_W-1:0]   s1_tag;

    logic               out_valid_r;
    logic [DATA_W-1:0]  out_data_r;
    logic [TAG_W-1:0]   out_tag_r;

    logic               s2_adv;
    logic               s1_adv;
    logic               in_fill;
    logic               in_rotate;
    logic [DATA_W-1:0]  sh16_data;
    logic [DATA_W-1:0]  sh8_data;
    logic [DATA_W-1:0]  sh4_data;
    logic [DATA_W-1:0]  sh2_data;
    logic [DATA_W-1:0]  sh1_data;

    assign s2_adv       = !out_valid_r || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_tag   = out_tag_r;

    assign in_fill = fill_for(bus.in_op, bus.in_data[DATA_W-1]);

`ifdef RIGHT_SHIFTER_ROTATE_EN
    assign in_rotate = (bus.in_op == OP_ROR);
`else
    assign in_rotate = 1'b0;
`endif

    right_shift_stage #(.DATA_W(DATA_W), .SHIFT_BY(16)) u_sh16 (
        .data_in  (bus.in_data),
        .enable   (bus.in_shamt[4]),
        .fill     (in_fill),
        .rotate   (in_rotate),
        .data_out (sh16_data)
    );

    right_shift_stage #(.DATA_W(DATA_W), .SHIFT_BY(8)) u_sh8 (
        .data_in  (sh16_data),
        .enable   (bus.in_shamt[3]),
        .fill     (in_fill),
        .rotate   (in_rotate),
        .data_out (sh8_data)
    );

    right_shift_stage #(.DATA_W(DATA_W), .SHIFT_BY(4)) u_sh4 (
        .data_in  (s1_data),
        .enable   (s1_shamt[2]),
        .fill     (s1_fill),
        .rotate   (s1_rotate),
        .data_out (sh4_data)
    );

    right_shift_stage #(.DATA_W(DATA_W), .SHIFT_BY(2)) u_sh2 (
        .data_in  (sh4_data),
        .enable   (s1_shamt[1]),
        .fill     (s1_fill),
        .rotate   (s1_rotate),
        .data_out (sh2_data)
    );

    right_shift_stage #(.DATA_W(DATA_W), .SHIFT_BY(1)) u_sh1 (
        .data_in  (sh2_data),
        .enable   (s1_shamt[0]),
        .fill     (s1_fill),
        .rotate   (s1_rotate),
        .data_out (sh1_data)
    );

    // Stage 1: capture the coarse-shifted operand and its context on an input transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_shamt  <= '0;
            s1_fill   <= 1'b0;
            s1_rotate <= 1'b0;
            s1_tag    <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data   <= sh8_data;
                s1_shamt  <= bus.in_shamt[2:0];
                s1_fill   <= in_fill;
                s1_rotate <= in_rotate;
                s1_tag    <= bus.in_tag;
            end
        end
    end

    // Stage 2: finish the shift into the output register, holding while the consumer stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_tag_r   <= '0;
        end else if (s2_adv) begin
            out_valid_r <= s1_valid;
            if (s1_valid) begin
                out_data_r <= sh1_data;
                out_tag_r  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_right_shifter.sv
// Directed self-checking bench for pipelined_right_shifter.
// Build with RIGHT_SHIFTER_ROTATE_EN defined to exercise the rotate variant.
module tb_pipelined_right_shifter;
    import shifter_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    pipelined_right_shifter_if #(.TAG_W(5)) bus ();

    pipelined_right_shifter #(.TAG_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] data,
                                  input logic [4:0] shamt, input logic [1:0] op,
                                  input logic [4:0] tag);
        bus.in_valid = valid;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_op    = op;
        bus.in_tag   = tag;
    endtask

    task automatic check_output(input string name, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    // Single operation with no backpressure: ready at issue, result exactly two cycles later.
    task automatic send_op(input string name, input logic [31:0] data, input logic [4:0] shamt,
                           input logic [1:0] op, input logic [4:0] tag,
                           input logic [31:0] expected);
        next_cycle();
        apply_stimulus(1'b1, data, shamt, op, tag);
        bus.out_ready = 1'b1;
        #1;
        check_output({name, "_rdy"}, {31'b0, bus.in_ready}, 32'd1);
        next_cycle();
        bus.in_valid = 1'b0;
        #1;
        check_output({name, "_v1"}, {31'b0, bus.out_valid}, 32'd0);
        next_cycle();
        check_output({name, "_v2"}, {31'b0, bus.out_valid}, 32'd1);
        check_output({name, "_data"}, bus.out_data, expected);
        check_output({name, "_tag"}, {27'b0, bus.out_tag}, {27'b0, tag});
    endtask

    initial begin
        $display("[TB] start");
        apply_stimulus(1'b0, 32'h0, 5'd0, OP_SRL, 5'd0);
        bus.out_ready = 1'b1;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check_output("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check_output("rst_data", bus.out_data, 32'h0);
        check_output("rst_tag", {27'b0, bus.out_tag}, 32'd0);
        check_output("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;

        // Basic shifts
        send_op("srl31", 32'h80000000, 5'd31, OP_SRL, 5'd5, 32'h00000001);
        send_op("sra4n", 32'h80000000, 5'd4, OP_SRA, 5'd6, 32'hF8000000);
        send_op("sra4p", 32'h7FFFFFF0, 5'd4, OP_SRA, 5'd7, 32'h07FFFFFF);
        send_op("sra20", 32'h80000000, 5'd20, OP_SRA, 5'd8, 32'hFFFFF800);
        send_op("srl27", 32'hDEADBEEF, 5'd27, OP_SRL, 5'd9, 32'h0000001B);
        send_op("z_srl", 32'hDEADBEEF, 5'd0, OP_SRL, 5'd10, 32'hDEADBEEF);
        send_op("z_sra", 32'hDEADBEEF, 5'd0, OP_SRA, 5'd11, 32'hDEADBEEF);
        send_op("z_op3", 32'hDEADBEEF, 5'd0, OP_RSVD, 5'd12, 32'hDEADBEEF);
        send_op("op3_8", 32'hDEADBEEF, 5'd8, OP_RSVD, 5'd13, 32'h00DEADBE);
`ifdef RIGHT_SHIFTER_ROTATE_EN
        send_op("ror1", 32'h00000001, 5'd1, OP_ROR, 5'd14, 32'h80000000);
        send_op("ror8", 32'h12345678, 5'd8, OP_ROR, 5'd15, 32'h78123456);
        send_op("ror31", 32'h00000003, 5'd31, OP_ROR, 5'd16, 32'h00000006);
`else
        send_op("op2_8", 32'h12345678, 5'd8, OP_ROR, 5'd14, 32'h00123456);
`endif

        // Drain check after the last single op
        next_cycle();
        check_output("drain", {31'b0, bus.out_valid}, 32'd0);

        // Stall: four ops back to back, consumer stalled cycles 2..6
        apply_stimulus(1'b1, 32'h11111111, 5'd4, OP_SRL, 5'd1);
        bus.out_ready = 1'b1;
        #1;
        check_output("st_c0_rdy", {31'b0, bus.in_ready}, 32'd1);
        next_cycle();
        apply_stimulus(1'b1, 32'h22222222, 5'd4, OP_SRL, 5'd2);
        #1;
        check_output("st_c1_rdy", {31'b0, bus.in_ready}, 32'd1);
        check_output("st_c1_v", {31'b0, bus.out_valid}, 32'd0);
        next_cycle();
        apply_stimulus(1'b1, 32'h33333333, 5'd4, OP_SRL, 5'd3);
        bus.out_ready = 1'b0;
        #1;
        check_output("st_c2_rdy", {31'b0, bus.in_ready}, 32'd0);
        check_output("st_c2_v", {31'b0, bus.out_valid}, 32'd1);
        check_output("st_c2_tag", {27'b0, bus.out_tag}, 32'd1);
        check_output("st_c2_data", bus.out_data, 32'h01111111);
        for (int c = 3; c <= 6; c++) begin
            next_cycle();
            check_output("st_hold_rdy", {31'b0, bus.in_ready}, 32'd0);
            check_output("st_hold_v", {31'b0, bus.out_valid}, 32'd1);
            check_output("st_hold_tag", {27'b0, bus.out_tag}, 32'd1);
            check_output("st_hold_data", bus.out_data, 32'h01111111);
        end
        next_cycle();
        bus.out_ready = 1'b1;
        #1;
        check_output("st_c7_rdy", {31'b0, bus.in_ready}, 32'd1);
        check_output("st_c7_tag", {27'b0, bus.out_tag}, 32'd1);
        next_cycle();
        apply_stimulus(1'b1, 32'h44444444, 5'd4, OP_SRL, 5'd4);
        #1;
        check_output("st_c8_v", {31'b0, bus.out_valid}, 32'd1);
        check_output("st_c8_tag", {27'b0, bus.out_tag}, 32'd2);
        check_output("st_c8_data", bus.out_data, 32'h02222222);
        next_cycle();
        bus.in_valid = 1'b0;
        #1;
        check_output("st_c9_tag", {27'b0, bus.out_tag}, 32'd3);
        check_output("st_c9_data", bus.out_data, 32'h03333333);
        next_cycle();
        check_output("st_c10_v", {31'b0, bus.out_valid}, 32'd1);
        check_output("st_c10_tag", {27'b0, bus.out_tag}, 32'd4);
        check_output("st_c10_data", bus.out_data, 32'h04444444);
        next_cycle();
        check_output("st_c11_v", {31'b0, bus.out_valid}, 32'd0);

        // Reset with two operations in flight
        next_cycle();
        apply_stimulus(1'b1, 32'hAAAA0000, 5'd16, OP_SRL, 5'd20);
        next_cycle();
        apply_stimulus(1'b1, 32'hBBBB0000, 5'd16, OP_SRL, 5'd21);
        next_cycle();
        bus.in_valid = 1'b0;
        #1;
        check_output("mf_pre_v", {31'b0, bus.out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("mf_rst_v", {31'b0, bus.out_valid}, 32'd0);
        check_output("mf_rst_data", bus.out_data, 32'h0);
        next_cycle();
        check_output("mf_hold_v", {31'b0, bus.out_valid}, 32'd0);
        reset_n = 1'b1;
        next_cycle();
        check_output("mf_rel_v", {31'b0, bus.out_valid}, 32'd0);
        next_cycle();
        check_output("mf_rel2_v", {31'b0, bus.out_valid}, 32'd0);
        send_op("mf_next", 32'hF0F0F0F0, 5'd12, OP_SRA, 5'd22, 32'hFFFF0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
